// File: rtl/turn_timer_pkg.sv
// Shared types and constants for the turn timer controller.
// Used by turn_timer_ctrl and seg7_hex_decoder.
package turn_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    EXPIRE,
    SWITCH,
    DONE
  } state_e;

  localparam int MISS_W = 2;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

endpackage

// File: rtl/turn_timer_ctrl_seg7.sv
// seg7_hex_decoder: hex nibble to active-low seven-segment pattern.
// Segment order is a..g on bit0..bit6.
module seg7_hex_decoder
  import turn_timer_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG7_BLANK;
    unique case (hex)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
    endcase
  end

endmodule

// File: rtl/turn_timer_ctrl.sv
// Two-player turn timer: per-turn countdown, timeouts, forfeit.
// Optional seven-segment output enabled by SEG7_DISPLAY_EN.
module turn_timer_ctrl
  import turn_timer_pkg::*;
#(
  parameter int TURN_SECONDS = 10,
  parameter int MAX_MISSES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       move_valid,
  input  logic       game_over,
  input  logic [3:0] count,
  output logic       timer_start,
  output logic       timer_clr,
  output logic       player,
  output logic [3:0] remaining,
  output logic       timeout,
  output logic       forfeit,
`ifdef SEG7_DISPLAY_EN
  output logic [6:0] seg_n,
`endif
  output logic       loser
);

  localparam logic [3:0] TS = 4'(TURN_SECONDS);
  localparam logic [MISS_W-1:0] MM = MISS_W'(MAX_MISSES);

  state_e state_q, state_d;
  logic player_q, player_d;
  logic forfeit_q, forfeit_d;
  logic loser_q, loser_d;
  logic [1:0][MISS_W-1:0] miss_q, miss_d;
  logic [MISS_W-1:0] miss_cur, miss_inc;

  assign miss_cur = miss_q[player_q];
  assign miss_inc = (&miss_cur) ? miss_cur
                  : miss_cur + MISS_W'(1);

  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    miss_d      = miss_q;
    forfeit_d   = forfeit_q;
    loser_d     = loser_q;
    timer_start = 1'b0;
    timer_clr   = 1'b0;
    timeout     = 1'b0;
    remaining   = 4'd0;
    unique case (state_q)
      IDLE: ;
      CLEAR: begin
        timer_clr = 1'b1;
        remaining = TS;
        state_d   = RUN;
      end
      RUN: begin
        timer_start = 1'b1;
        remaining   = (count >= TS) ? 4'd0 : TS - count;
        if (game_over) begin
          state_d = DONE;
        end else if (move_valid) begin
          state_d          = SWITCH;
          miss_d[player_q] = '0;
        end else if (count >= TS) begin
          state_d = EXPIRE;
        end
      end
      EXPIRE: begin
        timeout          = 1'b1;
        miss_d[player_q] = miss_inc;
        if (miss_inc >= MM) begin
          state_d   = DONE;
          forfeit_d = 1'b1;
          loser_d   = player_q;
        end else begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        remaining = TS;
        player_d  = ~player_q;
        state_d   = CLEAR;
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    // A new game overrides whatever the current state decided.
    if (game_start) begin
      state_d   = CLEAR;
      player_d  = 1'b0;
      miss_d    = '0;
      forfeit_d = 1'b0;
      loser_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      player_q  <= 1'b0;
      miss_q    <= '0;
      forfeit_q <= 1'b0;
      loser_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      miss_q    <= miss_d;
      forfeit_q <= forfeit_d;
      loser_q   <= loser_d;
    end
  end

  assign player  = player_q;
  assign forfeit = forfeit_q;
  assign loser   = loser_q;

`ifdef SEG7_DISPLAY_EN
  logic [6:0] hex_seg_n;

  seg7_hex_decoder u_seg7 (
    .hex   (remaining),
    .seg_n (hex_seg_n)
  );

  assign seg_n = (state_q == IDLE) ? SEG7_BLANK : hex_seg_n;
`endif

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// Scoreboard bench for turn_timer_ctrl (TURN_SECONDS=10, MAX_MISSES=3).
// Stimulus queues per-cycle expectations; a monitor compares them.
module tb_turn_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst, game_start, move_valid, game_over;
  logic [3:0] count;
  logic       timer_start, timer_clr, player, timeout;
  logic       forfeit, loser;
  logic [3:0] remaining;
`ifdef SEG7_DISPLAY_EN
  logic [6:0] seg_n;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      nm;
    logic [9:0] v;
    logic [7:0] sg;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  turn_timer_ctrl #(
    .TURN_SECONDS (10),
    .MAX_MISSES   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .game_start  (game_start),
    .move_valid  (move_valid),
    .game_over   (game_over),
    .count       (count),
    .timer_start (timer_start),
    .timer_clr   (timer_clr),
    .player      (player),
    .remaining   (remaining),
    .timeout     (timeout),
    .forfeit     (forfeit),
`ifdef SEG7_DISPLAY_EN
    .seg_n       (seg_n),
`endif
    .loser       (loser)
  );

  // Monitor: outputs are valid every cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e = sb.pop_front();
      act = {timer_start, timer_clr, timeout, player,
             forfeit, loser, remaining};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s got ts,clr,to,pl,ff,lo,rem=%b required %b",
                 e.nm, act, e.v);
      end
`ifdef SEG7_DISPLAY_EN
      if (e.sg[7]) begin
        checks++;
        if (seg_n !== e.sg[6:0]) begin
          failures++;
          $display("FAIL %s_seg got %b required %b",
                   e.nm, seg_n, e.sg[6:0]);
        end
      end
`endif
    end
  end

  task automatic cyc(input string nm,
                     input logic r, gs, mv, go,
                     input logic [3:0] c,
                     input logic ts, clr, to, pl, ff, lo,
                     input logic [3:0] rem,
                     input logic [7:0] sg = 8'h00);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; game_start = gs; move_valid = mv;
    game_over = go; count = c;
    e.nm = nm;
    e.v  = {ts, clr, to, pl, ff, lo, rem};
    e.sg = sg;
    sb.push_back(e);
  endtask

  // RUN cycle with a move, then SWITCH, then CLEAR for the other player.
  task automatic move_turn(input string nm, input logic p,
                           input logic [3:0] c, input logic [3:0] rem);
    cyc({nm, "_run"}, 0, 0, 1, 0, c, 1, 0, 0, p, 0, 0, rem);
    cyc({nm, "_sw"}, 0, 0, 0, 0, c, 0, 0, 0, p, 0, 0, 4'd10);
    cyc({nm, "_clr"}, 0, 0, 0, 0, 0, 0, 1, 0, ~p, 0, 0, 4'd10);
  endtask

  // RUN cycle reaching the limit, EXPIRE, then SWITCH and CLEAR.
  task automatic expire_turn(input string nm, input logic p);
    cyc({nm, "_run"}, 0, 0, 0, 0, 10, 1, 0, 0, p, 0, 0, 4'd0);
    cyc({nm, "_exp"}, 0, 0, 0, 0, 10, 0, 0, 1, p, 0, 0, 4'd0);
    cyc({nm, "_sw"}, 0, 0, 0, 0, 10, 0, 0, 0, p, 0, 0, 4'd10);
    cyc({nm, "_clr"}, 0, 0, 0, 0, 0, 0, 1, 0, ~p, 0, 0, 4'd10);
  endtask

  initial begin
    rst = 1'b1; game_start = 1'b0; move_valid = 1'b0;
    game_over = 1'b0; count = 4'd0;
    repeat (2) @(posedge clk);

    cyc("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
    cyc("idle_mv_ign", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle_start", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("first_clr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10);
    cyc("run_c0", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10);
    cyc("run_c1", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 9);
    cyc("run_c2", 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 8);
    cyc("run_c3_mv", 0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 7,
        {1'b1, 7'b1111000});
    cyc("mv_switch", 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 10);
    cyc("mv_clear_p1", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 10);

    move_turn("p1_mv_a", 1, 0, 10);
    expire_turn("p0_exp_a", 0);
    move_turn("p1_mv_b", 1, 4, 6);
    move_turn("p0_mv_clear", 0, 2, 8);
    move_turn("p1_mv_c", 1, 1, 9);
    expire_turn("p0_exp_b", 0);
    move_turn("p1_mv_d", 1, 0, 10);
    expire_turn("p0_exp_c", 0);
    move_turn("p1_mv_e", 1, 0, 10);

    move_turn("p0_mv_at_lim", 0, 10, 0);

    expire_turn("p1_exp_a", 1);
    move_turn("p0_mv_f", 0, 3, 7);
    expire_turn("p1_exp_b", 1);
    move_turn("p0_mv_g", 0, 3, 7);
    cyc("p1_exp_c_run", 0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0, 0);
    cyc("p1_exp_c_exp", 0, 0, 0, 0, 10, 0, 0, 1, 1, 0, 0, 0);
    cyc("forfeit_done", 0, 0, 1, 0, 10, 0, 0, 0, 1, 1, 1, 0);
    cyc("done_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);

    cyc("done_restart", 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    cyc("restart_clr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10);
    cyc("run_c0_b", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10);
    cyc("run_c7_rst", 1, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0, 3);
    cyc("after_rst", 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0);

    cyc("go_start", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("go_clr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10);
    cyc("go_run", 0, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0, 8);
    cyc("go_done", 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0);

    cyc("go_restart", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("gs_clr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10);
    move_turn("gs_p0_mv", 0, 1, 9);
    cyc("gs_in_run", 0, 1, 1, 0, 5, 1, 0, 0, 1, 0, 0, 5);
    cyc("gs_run_clr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10);
    cyc("sat_c12", 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0,
        {1'b1, 7'b1000000});
    cyc("gs_in_exp", 0, 1, 0, 0, 12, 0, 0, 1, 0, 0, 0, 0);
    cyc("gs_exp_clr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10);
    cyc("gs_exp_run", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain got %0d pending required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
